// File: rtl/axi_read_slave_mem.sv
// AXI4 read-channel responder backed by a word-organised memory.
// Serves FIXED/INCR bursts; a backdoor port preloads the image.
module axi_read_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;

    state_t state, nxt_state;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] cur_addr, nxt_cur_addr;
    logic [7:0]            burst_len, nxt_burst_len;
    logic [1:0]            burst_type, nxt_burst_type;
    logic [2:0]            beat_size, nxt_beat_size;
    logic [7:0]            beat_cnt, nxt_beat_cnt;
    logic [LW-1:0]         lat_cnt, nxt_lat_cnt;

    logic                  nxt_arready;
    logic                  nxt_rvalid;
    logic                  nxt_rlast;
    logic [1:0]            nxt_rresp;
    logic [DATA_WIDTH-1:0] nxt_rdata;
    logic                  load;

    logic [ADDR_WIDTH-1:0] step_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IW-1:0]         word_idx;
    logic                  in_range;
    logic                  bad_req;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [1:0]            beat_resp;

    // Beat 0 uses the captured address; later beats use the stepped one.
    assign step_addr = (burst_type == BT_INCR) ? cur_addr + ADDR_WIDTH'(4) : cur_addr;
    assign beat_addr = (state == BURST) ? step_addr : cur_addr;
    assign offset    = beat_addr - BASE_ADDR;
    assign in_range  = {1'b0, offset} < MEM_BYTES;
    assign word_idx  = offset[IW+1:2];
    assign bad_req   = ((burst_type != BT_FIXED) && (burst_type != BT_INCR))
                       || (beat_size != 3'b010);

    // Response and data for the beat about to be loaded.
    always_comb begin
        beat_data = '0;
        beat_resp = RESP_OKAY;
        if (bad_req) begin
            beat_resp = RESP_SLVERR;
        end else if (!in_range) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_data = mem[word_idx];
        end
    end

    // Backdoor write; a beat loaded on the same edge still sees old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        nxt_state      = state;
        nxt_arready    = arready;
        nxt_rvalid     = rvalid;
        nxt_rlast      = rlast;
        nxt_rresp      = rresp;
        nxt_rdata      = rdata;
        nxt_cur_addr   = cur_addr;
        nxt_burst_len  = burst_len;
        nxt_burst_type = burst_type;
        nxt_beat_size  = beat_size;
        nxt_beat_cnt   = beat_cnt;
        nxt_lat_cnt    = lat_cnt;
        load           = 1'b0;
        unique case (state)
            IDLE: begin
                nxt_arready = 1'b1;
                if (arvalid && arready) begin
                    nxt_arready    = 1'b0;
                    nxt_cur_addr   = araddr;
                    nxt_burst_len  = arlen;
                    nxt_burst_type = arburst;
                    nxt_beat_size  = arsize;
                    nxt_beat_cnt   = '0;
                    nxt_lat_cnt    = '0;
                    nxt_state      = LAT;
                end
            end
            LAT: begin
                if (lat_cnt == LAT_LAST) begin
                    load         = 1'b1;
                    nxt_beat_cnt = '0;
                    nxt_rlast    = (burst_len == 8'd0);
                    nxt_rvalid   = 1'b1;
                    nxt_state    = BURST;
                end else begin
                    nxt_lat_cnt = lat_cnt + LW'(1);
                end
            end
            BURST: begin
                if (rready) begin
                    if (rlast) begin
                        nxt_rvalid  = 1'b0;
                        nxt_rlast   = 1'b0;
                        nxt_arready = 1'b1;
                        nxt_state   = IDLE;
                    end else begin
                        load         = 1'b1;
                        nxt_cur_addr = step_addr;
                        nxt_beat_cnt = beat_cnt + 8'd1;
                        nxt_rlast    = ((beat_cnt + 8'd1) == burst_len);
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
        if (load) begin
            nxt_rdata = beat_data;
            nxt_rresp = beat_resp;
        end
    end

    // State and registered outputs; reset aborts any burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rresp      <= RESP_OKAY;
            rdata      <= '0;
            cur_addr   <= '0;
            burst_len  <= '0;
            burst_type <= '0;
            beat_size  <= '0;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
        end else begin
            state      <= nxt_state;
            arready    <= nxt_arready;
            rvalid     <= nxt_rvalid;
            rlast      <= nxt_rlast;
            rresp      <= nxt_rresp;
            rdata      <= nxt_rdata;
            cur_addr   <= nxt_cur_addr;
            burst_len  <= nxt_burst_len;
            burst_type <= nxt_burst_type;
            beat_size  <= nxt_beat_size;
            beat_cnt   <= nxt_beat_cnt;
            lat_cnt    <= nxt_lat_cnt;
        end
    end

endmodule
